// File: rtl/hazard_scoreboard_pkg.sv
// Shared constants for the hazard scoreboard: producer Tnew classes, consumer Tuse
// stages, forward-select encodings and the register-match helper.
package hazard_scoreboard_pkg;

    localparam int REG_W = 5;
    localparam int SEL_W = 2;

    localparam logic [1:0] TNEW_JAL = 2'd0;
    localparam logic [1:0] TNEW_ALU = 2'd1;
    localparam logic [1:0] TNEW_LD  = 2'd2;

    localparam logic [1:0] TUSE_D = 2'd0;
    localparam logic [1:0] TUSE_E = 2'd1;
    localparam logic [1:0] TUSE_M = 2'd2;

    // D-stage selects count from E (1) and M (2); E-stage selects count from M (1) and W (2).
    localparam logic [SEL_W-1:0] FWD_GRF      = 2'd0;
    localparam logic [SEL_W-1:0] FWD_E        = 2'd1;
    localparam logic [SEL_W-1:0] FWD_M        = 2'd2;
    localparam logic [SEL_W-1:0] FWD_E_FROM_M = 2'd1;
    localparam logic [SEL_W-1:0] FWD_W        = 2'd2;

    // $0 is hardwired, so it never matches a producer.
    function automatic logic regMatch(input logic [REG_W-1:0] a3, input logic [REG_W-1:0] r);
        return (a3 == r) && (r != '0);
    endfunction

endpackage

// File: rtl/hazard_scoreboard_cmp.sv
// One D-stage operand checked against the E and M producers: stall request and
// D-stage forward select.
module hazard_cmp
    import hazard_scoreboard_pkg::*;
#(
    parameter int TNEW_W = 2
) (
    input  logic [REG_W-1:0]  src_i,
    input  logic              used_i,
    input  logic [TNEW_W-1:0] tuse_i,
    input  logic [REG_W-1:0]  eA3_i,
    input  logic [TNEW_W-1:0] eTnew_i,
    input  logic [REG_W-1:0]  mA3_i,
    input  logic [TNEW_W-1:0] mTnew_i,
    output logic              stall_o,
    output logic [SEL_W-1:0]  fwd_o
);

    logic eHit;
    logic mHit;

    // The younger producer (E) takes priority when both stages write the same register.
    always_comb begin
        eHit    = regMatch(eA3_i, src_i);
        mHit    = regMatch(mA3_i, src_i);
        stall_o = used_i && ((eHit && (eTnew_i > tuse_i)) || (mHit && (mTnew_i > tuse_i)));
        fwd_o   = FWD_GRF;
        if (eHit && (eTnew_i == '0)) begin
            fwd_o = FWD_E;
        end else if (mHit && (mTnew_i == '0)) begin
            fwd_o = FWD_M;
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// Shadow E/M/W pipeline of destination registers and Tnew, driving stall,
// forwarding selects and a saturating stall-cycle counter.
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int CNT_W  = 32,
    parameter int TNEW_W = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_W-1:0]  D_rs,
    input  logic [REG_W-1:0]  D_rt,
    input  logic              D_rs_Tuse,
    input  logic              D_rt_Tuse,
    input  logic              E_rs_Tuse,
    input  logic              E_rt_Tuse,
    input  logic              M_rt_use,
    input  logic [REG_W-1:0]  D_A3,
    input  logic [TNEW_W-1:0] D_Tnew,
    output logic              stall,
    output logic [SEL_W-1:0]  D_fwd_rs,
    output logic [SEL_W-1:0]  D_fwd_rt,
    output logic [SEL_W-1:0]  E_fwd_rs,
    output logic [SEL_W-1:0]  E_fwd_rt,
    output logic              M_fwd_rt,
    output logic [CNT_W-1:0]  stall_cnt
);

    logic [REG_W-1:0]  eRs_q, eRs_d, eRt_q, eRt_d, eA3_q, eA3_d;
    logic [TNEW_W-1:0] eTnew_q, eTnew_d;
    logic [REG_W-1:0]  mRt_q, mRt_d, mA3_q, mA3_d;
    logic [TNEW_W-1:0] mTnew_q, mTnew_d;
    logic [REG_W-1:0]  wA3_q, wA3_d;
    logic [CNT_W-1:0]  stallCnt_q, stallCnt_d;

    logic              rsUsed, rtUsed;
    logic [TNEW_W-1:0] rsTuse, rtTuse;
    logic              stallRs, stallRt;

    // Earliest consuming stage wins; an operand with no use flag can never stall.
    always_comb begin
        rsUsed = D_rs_Tuse | E_rs_Tuse;
        rtUsed = D_rt_Tuse | E_rt_Tuse | M_rt_use;
        rsTuse = D_rs_Tuse ? TNEW_W'(TUSE_D) : TNEW_W'(TUSE_E);
        rtTuse = D_rt_Tuse ? TNEW_W'(TUSE_D) : (E_rt_Tuse ? TNEW_W'(TUSE_E) : TNEW_W'(TUSE_M));
    end

    hazard_cmp #(.TNEW_W(TNEW_W)) u_cmpRs (
        .src_i   (D_rs),
        .used_i  (rsUsed),
        .tuse_i  (rsTuse),
        .eA3_i   (eA3_q),
        .eTnew_i (eTnew_q),
        .mA3_i   (mA3_q),
        .mTnew_i (mTnew_q),
        .stall_o (stallRs),
        .fwd_o   (D_fwd_rs)
    );

    hazard_cmp #(.TNEW_W(TNEW_W)) u_cmpRt (
        .src_i   (D_rt),
        .used_i  (rtUsed),
        .tuse_i  (rtTuse),
        .eA3_i   (eA3_q),
        .eTnew_i (eTnew_q),
        .mA3_i   (mA3_q),
        .mTnew_i (mTnew_q),
        .stall_o (stallRt),
        .fwd_o   (D_fwd_rt)
    );

    assign stall     = stallRs | stallRt;
    assign stall_cnt = stallCnt_q;

    always_comb begin
        E_fwd_rs = FWD_GRF;
        E_fwd_rt = FWD_GRF;
        if (regMatch(mA3_q, eRs_q) && (mTnew_q == '0)) begin
            E_fwd_rs = FWD_E_FROM_M;
        end else if (regMatch(wA3_q, eRs_q)) begin
            E_fwd_rs = FWD_W;
        end
        if (regMatch(mA3_q, eRt_q) && (mTnew_q == '0)) begin
            E_fwd_rt = FWD_E_FROM_M;
        end else if (regMatch(wA3_q, eRt_q)) begin
            E_fwd_rt = FWD_W;
        end
        M_fwd_rt = regMatch(wA3_q, mRt_q);
    end

    // A stall injects an all-zero bubble into E; Tnew drains by one per stage, floored at 0.
    always_comb begin
        eRs_d      = stall ? '0 : D_rs;
        eRt_d      = stall ? '0 : D_rt;
        eA3_d      = stall ? '0 : D_A3;
        eTnew_d    = stall ? '0 : D_Tnew;
        mRt_d      = eRt_q;
        mA3_d      = eA3_q;
        mTnew_d    = (eTnew_q == '0) ? '0 : eTnew_q - TNEW_W'(1);
        wA3_d      = mA3_q;
        stallCnt_d = (stall && (stallCnt_q != '1)) ? stallCnt_q + CNT_W'(1) : stallCnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            eRs_q      <= '0;
            eRt_q      <= '0;
            eA3_q      <= '0;
            eTnew_q    <= '0;
            mRt_q      <= '0;
            mA3_q      <= '0;
            mTnew_q    <= '0;
            wA3_q      <= '0;
            stallCnt_q <= '0;
        end else begin
            eRs_q      <= eRs_d;
            eRt_q      <= eRt_d;
            eA3_q      <= eA3_d;
            eTnew_q    <= eTnew_d;
            mRt_q      <= mRt_d;
            mA3_q      <= mA3_d;
            mTnew_q    <= mTnew_d;
            wA3_q      <= wA3_d;
            stallCnt_q <= stallCnt_d;
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: instruction sequences drive the D stage,
// expected outputs are queued per cycle and compared against the DUT.
module tb_hazard_scoreboard;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  D_rs, D_rt, D_A3;
    logic        D_rs_Tuse, D_rt_Tuse, E_rs_Tuse, E_rt_Tuse, M_rt_use;
    logic [1:0]  D_Tnew;
    logic        stall;
    logic [1:0]  D_fwd_rs, D_fwd_rt, E_fwd_rs, E_fwd_rt;
    logic        M_fwd_rt;
    logic [31:0] stall_cnt;

    typedef struct {
        logic [4:0] rs, rt, a3;
        logic       dRs, dRt, eRs, eRt, mRt;
        logic [1:0] tnew;
    } instr_t;

    typedef struct {
        logic        stall;
        logic [1:0]  dFwdRs, dFwdRt, eFwdRs, eFwdRt;
        logic        mFwdRt;
        logic [31:0] cnt;
    } expect_t;

    expect_t expQ[$];
    int      checks   = 0;
    int      failures = 0;
    int      expCnt   = 0;

    hazard_scoreboard #(.CNT_W(32), .TNEW_W(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .D_rs      (D_rs),
        .D_rt      (D_rt),
        .D_rs_Tuse (D_rs_Tuse),
        .D_rt_Tuse (D_rt_Tuse),
        .E_rs_Tuse (E_rs_Tuse),
        .E_rt_Tuse (E_rt_Tuse),
        .M_rt_use  (M_rt_use),
        .D_A3      (D_A3),
        .D_Tnew    (D_Tnew),
        .stall     (stall),
        .D_fwd_rs  (D_fwd_rs),
        .D_fwd_rt  (D_fwd_rt),
        .E_fwd_rs  (E_fwd_rs),
        .E_fwd_rt  (E_fwd_rt),
        .M_fwd_rt  (M_fwd_rt),
        .stall_cnt (stall_cnt)
    );

    always #5 clk = ~clk;

    function automatic instr_t mkIns(input int rs, input int rt, input int dRs, input int dRt,
                                     input int eRs, input int eRt, input int mRt,
                                     input int a3, input int tnew);
        instr_t i;
        i.rs   = 5'(rs);
        i.rt   = 5'(rt);
        i.dRs  = (dRs != 0);
        i.dRt  = (dRt != 0);
        i.eRs  = (eRs != 0);
        i.eRt  = (eRt != 0);
        i.mRt  = (mRt != 0);
        i.a3   = 5'(a3);
        i.tnew = 2'(tnew);
        return i;
    endfunction

    function automatic expect_t mkExp(input int st, input int dRs, input int dRt,
                                      input int eRs, input int eRt, input int mRt);
        expect_t e;
        e.stall  = (st != 0);
        e.dFwdRs = 2'(dRs);
        e.dFwdRt = 2'(dRt);
        e.eFwdRs = 2'(eRs);
        e.eFwdRt = 2'(eRt);
        e.mFwdRt = (mRt != 0);
        e.cnt    = '0;
        return e;
    endfunction

    task automatic checkValue(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, want);
        end
    endtask

    task automatic applyStimulus(input instr_t ins, input expect_t e);
        D_rs      = ins.rs;
        D_rt      = ins.rt;
        D_rs_Tuse = ins.dRs;
        D_rt_Tuse = ins.dRt;
        E_rs_Tuse = ins.eRs;
        E_rt_Tuse = ins.eRt;
        M_rt_use  = ins.mRt;
        D_A3      = ins.a3;
        D_Tnew    = ins.tnew;
        e.cnt     = 32'(expCnt);
        expQ.push_back(e);
    endtask

    task automatic checkOutput(input string tag);
        expect_t e;
        if (expQ.size() == 0) begin
            checkValue({tag, ".queue"}, 32'd0, 32'd1);
            return;
        end
        e = expQ.pop_front();
        checkValue({tag, ".stall"},     {31'd0, stall},    {31'd0, e.stall});
        checkValue({tag, ".D_fwd_rs"},  {30'd0, D_fwd_rs}, {30'd0, e.dFwdRs});
        checkValue({tag, ".D_fwd_rt"},  {30'd0, D_fwd_rt}, {30'd0, e.dFwdRt});
        checkValue({tag, ".E_fwd_rs"},  {30'd0, E_fwd_rs}, {30'd0, e.eFwdRs});
        checkValue({tag, ".E_fwd_rt"},  {30'd0, E_fwd_rt}, {30'd0, e.eFwdRt});
        checkValue({tag, ".M_fwd_rt"},  {31'd0, M_fwd_rt}, {31'd0, e.mFwdRt});
        checkValue({tag, ".stall_cnt"}, stall_cnt,         e.cnt);
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic step(input string tag, input instr_t ins, input expect_t e);
        applyStimulus(ins, e);
        #2;
        checkOutput(tag);
        if (e.stall) expCnt++;
        @(negedge clk);
    endtask

    task automatic doReset(input instr_t nop, input expect_t zero);
        rst_n  = 1'b0;
        expCnt = 0;
        applyStimulus(nop, zero);
        #2;
        checkOutput("reset");
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    instr_t  NOP, LW1, ADDU213, BEQ10, ADDU4, BEQ44, JAL, JR31, ADDU0, ADDU600, LW5, SW5;
    expect_t Z;

    initial begin
        NOP     = mkIns(0, 0, 0, 0, 0, 0, 0, 0, 0);
        LW1     = mkIns(0, 0, 0, 0, 1, 0, 0, 1, 2);
        ADDU213 = mkIns(1, 3, 0, 0, 1, 1, 0, 2, 1);
        BEQ10   = mkIns(1, 0, 1, 1, 0, 0, 0, 0, 0);
        ADDU4   = mkIns(0, 0, 0, 0, 1, 1, 0, 4, 1);
        BEQ44   = mkIns(4, 4, 1, 1, 0, 0, 0, 0, 0);
        JAL     = mkIns(0, 0, 0, 0, 0, 0, 0, 31, 0);
        JR31    = mkIns(31, 0, 1, 0, 0, 0, 0, 0, 0);
        ADDU0   = mkIns(0, 0, 0, 0, 1, 1, 0, 0, 1);
        ADDU600 = mkIns(0, 0, 0, 0, 1, 1, 0, 6, 1);
        LW5     = mkIns(0, 0, 0, 0, 1, 0, 0, 5, 2);
        SW5     = mkIns(0, 5, 0, 0, 1, 0, 1, 0, 0);
        Z       = mkExp(0, 0, 0, 0, 0, 0);

        rst_n = 1'b1;
        applyStimulus(NOP, Z);
        void'(expQ.pop_front());
        @(negedge clk);
        doReset(NOP, Z);

        // lw $1 ; addu $2,$1,$3 : one stall, then E-stage forward from W
        step("s1.lw",    LW1,     Z);
        step("s1.stall", ADDU213, mkExp(1, 0, 0, 0, 0, 0));
        step("s1.held",  ADDU213, Z);
        step("s1.fwdW",  NOP,     mkExp(0, 0, 0, 2, 0, 0));
        step("s1.drain", NOP,     Z);

        // lw $1 ; beq $1,$0 : two stalls, then GRF
        doReset(NOP, Z);
        step("s2.lw",     LW1,   Z);
        step("s2.stall1", BEQ10, mkExp(1, 0, 0, 0, 0, 0));
        step("s2.stall2", BEQ10, mkExp(1, 0, 0, 0, 0, 0));
        step("s2.go",     BEQ10, Z);

        // reset asserted in the middle of a lw-use stall
        step("s6.lw", LW1, Z);
        applyStimulus(ADDU213, mkExp(1, 0, 0, 0, 0, 0));
        #2;
        checkOutput("s6.stall");
        #1;
        rst_n  = 1'b0;
        expCnt = 0;
        applyStimulus(ADDU213, Z);
        #1;
        checkOutput("s6.async");
        @(negedge clk);
        rst_n = 1'b1;
        step("s6.after", ADDU213, Z);

        // addu $4 ; beq $4,$4 : one stall, then both operands from M
        doReset(NOP, Z);
        step("s3.addu",  ADDU4, Z);
        step("s3.stall", BEQ44, mkExp(1, 0, 0, 0, 0, 0));
        step("s3.fwdM",  BEQ44, mkExp(0, 2, 2, 0, 0, 0));
        step("s3.eFwdW", NOP,   mkExp(0, 0, 0, 2, 2, 0));

        // jal ; jr $31 : no stall, forward PC+8 from E
        doReset(NOP, Z);
        step("s4.jal",   JAL,  Z);
        step("s4.fwdE",  JR31, mkExp(0, 1, 0, 0, 0, 0));
        step("s4.eFwdM", NOP,  mkExp(0, 0, 0, 1, 0, 0));

        // $0 never hazards; lw $5 ; sw $5 forwards store data from W
        doReset(NOP, Z);
        step("s5.addu0",   ADDU0,   Z);
        step("s5.zeroUse", ADDU600, Z);
        step("s5.lw",      LW5,     Z);
        step("s5.sw",      SW5,     Z);
        step("s5.wait",    NOP,     Z);
        step("s5.mFwdW",   NOP,     mkExp(0, 0, 0, 0, 0, 1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
